// File: rtl/memory_access.sv
//==============================================================================
// Module      : memory_access
// Description : EX/MEM pipeline register plus memory-stage control. Captures
//               the execute-stage outputs, resolves CBZ-type branches and runs
//               aligned loads/stores against a variable-latency data memory
//               through a req/ack handshake. The upstream pipeline is frozen
//               while a request is outstanding.
// Ports       : clk/reset           - clock, synchronous active-high reset
//               *_E                 - execute-stage instruction fields
//               stall_out           - freeze PC, IF/ID and ID/EX
//               dm_req/we/addr/wdata, dm_ack/rdata - data memory handshake
//               *_M                 - results presented to writeback
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module memory_access #(
    parameter int size = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_E,
    input  logic              memRead_E,
    input  logic              memWrite_E,
    input  logic              branch_E,
    input  logic [size-1:0]   aluResult_E,
    input  logic [size-1:0]   writeData_E,
    input  logic [size-1:0]   PCBranch_E,
    input  logic              zero_E,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [size-1:0]   dm_addr,
    output logic [size-1:0]   dm_wdata,
    input  logic              dm_ack,
    input  logic [size-1:0]   dm_rdata,
    output logic              valid_M,
    output logic [size-1:0]   aluResult_M,
    output logic [size-1:0]   readData_M,
    output logic              PCSrc_M,
    output logic [size-1:0]   PCBranch_M,
    output logic              misalign_M
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      state_q,      state_d;
    logic            valid_q,      valid_d;
    logic            mem_read_q,   mem_read_d;
    logic            mem_write_q,  mem_write_d;
    logic            branch_q,     branch_d;
    logic            zero_q,       zero_d;
    logic [size-1:0] alu_result_q, alu_result_d;
    logic [size-1:0] write_data_q, write_data_d;
    logic [size-1:0] pc_branch_q,  pc_branch_d;
    logic [size-1:0] read_data_q,  read_data_d;

    logic w_in_wait;
    logic w_start_mem;

    // Stall depends only on registered state: no dm_ack -> stall path.
    assign w_in_wait   = (state_q == c_WAIT);
    assign w_start_mem = valid_E & (memRead_E | memWrite_E) &
                         (aluResult_E[2:0] == 3'b000);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_branch_d  = pc_branch_q;
        read_data_d  = read_data_q;

        if (!w_in_wait) begin
            // IDLE and DONE both accept the next instruction every edge;
            // a stray dm_ack here has no effect.
            valid_d      = valid_E;
            mem_read_d   = memRead_E;
            mem_write_d  = memWrite_E;
            branch_d     = branch_E;
            zero_d       = zero_E;
            alu_result_d = aluResult_E;
            write_data_d = writeData_E;
            pc_branch_d  = PCBranch_E;
            state_d      = w_start_mem ? c_WAIT : c_IDLE;
        end else if (dm_ack) begin
            // Read+write together behaves as a store: load data is not taken.
            if (mem_read_q && !mem_write_q) begin
                read_data_d = dm_rdata;
            end
            state_d = c_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_IDLE;
            valid_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_branch_q  <= '0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_branch_q  <= pc_branch_d;
            read_data_q  <= read_data_d;
        end
    end

    // Memory interface is only driven while a request is outstanding, which
    // keeps the fields quiet (and stable) outside WAIT.
    assign stall_out = w_in_wait;
    assign dm_req    = w_in_wait;
    assign dm_we     = w_in_wait & mem_write_q;
    assign dm_addr   = w_in_wait ? alu_result_q : '0;
    assign dm_wdata  = w_in_wait ? write_data_q : '0;

    assign valid_M     = valid_q & ~w_in_wait;
    assign aluResult_M = alu_result_q;
    assign readData_M  = read_data_q;
    assign PCSrc_M     = valid_M & branch_q & zero_q;
    assign PCBranch_M  = pc_branch_q;
    assign misalign_M  = valid_q & (mem_read_q | mem_write_q) &
                         (alu_result_q[2:0] != 3'b000);

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
//==============================================================================
// Module      : tb_memory_access
// Description : Self-checking bench for memory_access. A driver issues
//               directed and random instructions and pushes expected results
//               and expected memory requests into queues; a memory responder
//               and a writeback monitor pop and compare independently.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_E, memRead_E, memWrite_E, branch_E, zero_E;
    logic [63:0] aluResult_E, writeData_E, PCBranch_E;
    logic        stall_out, dm_req, dm_we, dm_ack;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        valid_M, PCSrc_M, misalign_M;
    logic [63:0] aluResult_M, readData_M, PCBranch_M;

    always #5 clk = ~clk;

    memory_access #(.size(64)) dut (
        .clk(clk), .reset(reset),
        .valid_E(valid_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
        .branch_E(branch_E), .aluResult_E(aluResult_E),
        .writeData_E(writeData_E), .PCBranch_E(PCBranch_E), .zero_E(zero_E),
        .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .valid_M(valid_M), .aluResult_M(aluResult_M),
        .readData_M(readData_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
        .misalign_M(misalign_M)
    );

    typedef struct {
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [63:0] pcb;
        logic        pcsrc;
        logic        mis;
    } res_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    res_t        exp_q[$];
    req_t        req_q[$];
    logic [63:0] ref_mem[logic [63:0]];
    logic [63:0] dev_mem[logic [63:0]];
    logic [63:0] last_rd;

    int tests = 0;
    int fails = 0;

    // Responder / manual ack sources are kept separate and muxed.
    logic        manual = 1'b0;
    logic        man_ack = 1'b0;
    logic [63:0] man_rdata = '0;
    logic        resp_ack = 1'b0;
    logic [63:0] resp_rdata = '0;
    int          forced_lat = 0;

    assign dm_ack   = manual ? man_ack   : resp_ack;
    assign dm_rdata = manual ? man_rdata : resp_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return a ^ 64'hA5A5_0000_1234_5678;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_rand_garbage();
        valid_E     = 1'($urandom);
        memRead_E   = 1'($urandom);
        memWrite_E  = 1'($urandom);
        branch_E    = 1'($urandom);
        zero_E      = 1'($urandom);
        aluResult_E = rnd64();
        writeData_E = rnd64();
        PCBranch_E  = rnd64();
    endtask

    task automatic drive_bubble();
        valid_E = 0; memRead_E = 0; memWrite_E = 0; branch_E = 0; zero_E = 0;
        aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
    endtask

    // Wait for a negedge where the stage is not stalled, then present the
    // instruction (captured on the next posedge) and record expectations.
    task automatic issue(input logic v, input logic rd, input logic wr,
                         input logic br, input logic z, input logic [63:0] alu,
                         input logic [63:0] wd, input logic [63:0] pcb);
        int   guard;
        logic is_mem, mis;
        res_t r;
        guard = 0;
        @(negedge clk);
        while (stall_out && guard < 200) begin
            drive_rand_garbage();
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            chk("issue_timeout", 64'(stall_out), 64'd0);
        end
        valid_E = v; memRead_E = rd; memWrite_E = wr; branch_E = br; zero_E = z;
        aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;

        is_mem = v && (rd || wr);
        mis    = is_mem && (alu[2:0] != 3'b000);
        if (is_mem && !mis) begin
            req_q.push_back('{we: wr, addr: alu, wdata: wd});
            if (wr) ref_mem[alu] = wd;
            else    last_rd = ref_mem.exists(alu) ? ref_mem[alu] : dflt(alu);
        end
        if (v) begin
            r.alu = alu; r.rdata = last_rd; r.pcb = pcb;
            r.pcsrc = br && z; r.mis = mis;
            exp_q.push_back(r);
        end
    endtask

    // Memory responder: checks request fields, acks after a chosen latency.
    req_t cur;
    logic busy = 1'b0, acked = 1'b0;
    int   lat = 1, cnt = 0;
    always @(negedge clk) begin
        if (!manual && !reset) begin
            if (dm_req) begin
                if (!busy) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 64'(dm_req), 64'd0);
                        cur = '{we: dm_we, addr: dm_addr, wdata: dm_wdata};
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_we", 64'(dm_we), 64'(cur.we));
                        chk("req_addr", dm_addr, cur.addr);
                        chk("req_wdata", dm_wdata, cur.wdata);
                    end
                    lat   = (forced_lat != 0) ? forced_lat : int'($urandom_range(1, 4));
                    cnt   = 0;
                    busy  = 1'b1;
                    acked = 1'b0;
                end else begin
                    chk("req_stable", {dm_addr[31:0], dm_wdata[30:0], dm_we},
                        {cur.addr[31:0], cur.wdata[30:0], cur.we});
                end
                cnt++;
                if (cnt > lat) chk("req_after_ack", 64'(dm_req), 64'd0);
                if (cnt == lat) begin
                    resp_ack = 1'b1;
                    if (cur.we) begin
                        dev_mem[cur.addr] = cur.wdata;
                        resp_rdata = rnd64();
                    end else begin
                        resp_rdata = dev_mem.exists(cur.addr) ? dev_mem[cur.addr] : dflt(cur.addr);
                    end
                    acked = 1'b1;
                end else begin
                    resp_ack   = 1'b0;
                    resp_rdata = rnd64();
                end
            end else begin
                if (busy && !acked) chk("req_dropped", 64'(dm_req), 64'd1);
                if (busy && acked)  chk("done_valid", 64'(valid_M), 64'd1);
                busy     = 1'b0;
                acked    = 1'b0;
                resp_ack = ($urandom_range(0, 7) == 0); // stray ack outside WAIT
                resp_rdata = rnd64();
            end
        end else begin
            resp_ack = 1'b0;
            busy     = 1'b0;
            acked    = 1'b0;
        end
    end

    // Writeback monitor.
    always @(negedge clk) begin
        if (!manual && !reset) begin
            if (stall_out !== dm_req) chk("stall_eq_req", 64'(stall_out), 64'(dm_req));
            if (valid_M) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(valid_M), 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("aluResult_M", aluResult_M, e.alu);
                    chk("readData_M", readData_M, e.rdata);
                    chk("PCSrc_M", 64'(PCSrc_M), 64'(e.pcsrc));
                    chk("PCBranch_M", PCBranch_M, e.pcb);
                    chk("misalign_M", 64'(misalign_M), 64'(e.mis));
                end
            end
        end
    end

    function automatic logic [63:0] out_or();
        return aluResult_M | readData_M | PCBranch_M | dm_addr | dm_wdata |
               64'({stall_out, dm_req, dm_we, valid_M, PCSrc_M, misalign_M});
    endfunction

    initial begin
        last_rd = '0;
        reset = 1'b1;
        drive_rand_garbage();
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_outputs", out_or(), 64'd0);
            drive_rand_garbage();
        end
        drive_bubble();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bubble_outputs", out_or(), 64'd0);
        end

        // Directed load, 3 request cycles.
        ref_mem[64'h10] = 64'hDEADBEEF;
        dev_mem[64'h10] = 64'hDEADBEEF;
        forced_lat = 3;
        issue(1, 1, 0, 0, 0, 64'h10, 64'h0, 64'h0);
        // Directed store, zero wait state.
        forced_lat = 1;
        issue(1, 0, 1, 0, 0, 64'h20, 64'h1234, 64'h0);
        forced_lat = 0;
        // Branch taken / not taken.
        issue(1, 0, 0, 1, 1, 64'h0, 64'h0, 64'h40);
        issue(1, 0, 0, 1, 0, 64'h0, 64'h0, 64'h40);
        // Misaligned load.
        issue(1, 1, 0, 0, 0, 64'h13, 64'h0, 64'h0);
        // Read+write together acts as a store.
        issue(1, 1, 1, 0, 0, 64'h10, 64'h5555, 64'h0);
        issue(1, 1, 0, 0, 0, 64'h10, 64'h0, 64'h0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            logic [63:0] a;
            a = {57'(0), 4'($urandom), 3'b000};
            if ($urandom_range(0, 3) == 0) a[2:0] = 3'($urandom);
            issue(($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), a, rnd64(), rnd64());
        end

        // Drain.
        issue(0, 0, 0, 0, 0, '0, '0, '0);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || req_q.size() != 0); i++)
            @(negedge clk);
        chk("drain_results", 64'(exp_q.size()), 64'd0);
        chk("drain_requests", 64'(req_q.size()), 64'd0);

        // Reset in the second WAIT cycle; late ack must be ignored.
        manual = 1'b1;
        issue(1, 1, 0, 0, 0, 64'h30, 64'h0, 64'h0);
        req_q.delete();
        @(negedge clk);
        drive_bubble();
        chk("rst_wait1_req", 64'(dm_req), 64'd1);
        @(negedge clk);
        chk("rst_wait2_req", 64'(dm_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_drop", 64'(dm_req), 64'd0);
        chk("rst_outputs", out_or(), 64'd0);
        exp_q.delete();
        last_rd = '0;
        @(negedge clk);
        man_ack = 1'b1;
        man_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_stall", 64'(stall_out), 64'd0);
        chk("late_ack_req", 64'(dm_req), 64'd0);
        chk("late_ack_rdata", readData_M, 64'd0);
        chk("late_ack_valid", 64'(valid_M), 64'd0);
        manual = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_access.md
Name: memory_access

Overview:
- Consumer end of the execute-stage interface.
- Registers the execute outputs (EX/MEM pipeline register), resolves the conditional branch, and runs loads/stores against a variable-latency data memory through a req/ack handshake.
- Stalls the upstream pipeline until the memory transaction completes, then presents results to writeback.

Parameters:
size, 64, data/address width; matches the execute stage datapath width.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
valid_E  in  1  execute stage holds a real instruction
memRead_E  in  1  instruction is a load
memWrite_E  in  1  instruction is a store
branch_E  in  1  instruction is CBZ-type branch
aluResult_E  in  size  effective address / ALU result
writeData_E  in  size  store data
PCBranch_E  in  size  branch target
zero_E  in  1  ALU zero flag
stall_out  out  1  freeze PC, IF/ID and ID/EX registers
dm_req  out  1  memory request
dm_we  out  1  1 = write, 0 = read
dm_addr  out  size  memory address
dm_wdata  out  size  memory write data
dm_ack  in  1  memory completion (one-cycle pulse)
dm_rdata  in  size  read data, valid with dm_ack
valid_M  out  1  M-stage result ready for writeback this cycle
aluResult_M  out  size  registered ALU result
readData_M  out  size  load data
PCSrc_M  out  1  take branch
PCBranch_M  out  size  registered branch target
misalign_M  out  1  memory op with addr[2:0] != 0

Behaviour:
- Reset (synchronous, active-high): all registers cleared, state IDLE, every output 0.
- Reset has priority over all other events, including mid-transaction. Reset in WAIT drops dm_req the following cycle and abandons the access. A later dm_ack is ignored.
- States:
  - IDLE: holds a non-memory instruction or a bubble.
  - WAIT: request outstanding.
  - DONE: load/store completed.
- Capture: on every edge with stall_out=0, the EX/MEM register loads all *_E inputs.
  - Next state WAIT if valid_E & (memRead_E | memWrite_E) & aluResult_E[2:0]==0.
  - Otherwise next state IDLE.
- Both memRead_E and memWrite_E set: treated as a store; the read is suppressed.
- Misaligned memory op: no dm_req is issued. misalign_M=1 while the instruction is in M, and it completes like a non-memory op.
- WAIT:
  - dm_req=1; dm_we=memWrite_M; dm_addr=aluResult_M; dm_wdata=writeData_M.
  - All four outputs are held stable until ack.
  - stall_out=1.
  - On edge with dm_ack=1: readData_M<=dm_rdata for a load (unchanged for a store), then go to DONE.
  - Zero-wait-state memory (ack in the first WAIT cycle) is legal: exactly one request cycle.
- DONE: stall_out=0, dm_req=0. Next edge captures the following instruction.
- stall_out=1 only in WAIT, driven from a registered state only (no dm_ack→stall combinational path).
- Occupancy: a non-memory op sits in M for 1 cycle. A memory op sits in M for (ack latency in cycles, counting the request cycle) + 1 cycles.
- valid_M = valid_M register & (state != WAIT).
- PCSrc_M = valid_M & branch_M & zero_M. PCBranch_M and aluResult_M are the registered *_E values.
- dm_ack in IDLE or DONE is ignored; no state change.
- dm_req is never asserted for bubbles (valid_E=0).

Test Plan:
1. Reset held 2 cycles with random inputs -> every output 0, state IDLE. Release with bubbles -> outputs stay 0.
2. Load: addr 0x10, dm_ack after 3 request cycles with rdata 0xDEADBEEF -> dm_req=1/dm_we=0/dm_addr=0x10 for 3 cycles, stall_out=1 for the same 3 cycles, then one DONE cycle with valid_M=1, readData_M=0xDEADBEEF.
3. Store: addr 0x20, wdata 0x1234, ack in first cycle -> exactly one cycle of dm_req=1/dm_we=1/dm_wdata=0x1234, stall_out one cycle, next instruction captured on the edge after DONE.
4. Branch: branch_E=1, zero_E=1, PCBranch_E=0x40 -> next cycle PCSrc_M=1, PCBranch_M=0x40, no dm_req. Repeat with zero_E=0 -> PCSrc_M=0.
5. Misaligned load at 0x13 -> no dm_req, stall_out=0, misalign_M=1, valid_M=1 for one cycle.
6. Reset asserted in the 2nd WAIT cycle, dm_ack pulsed 1 cycle after reset release -> dm_req=0 after the reset edge, ack ignored, state IDLE, readData_M=0.
